// File: rtl/hazard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard: stall-cause bit
// positions and nominal producer latencies.
package hazard_pkg;

  localparam int CAUSE_RAW    = 0;
  localparam int CAUSE_WAW    = 1;
  localparam int CAUSE_STRUCT = 2;
  localparam int CAUSE_W      = 3;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;
  localparam int LAT_VEC  = 4;

  typedef logic [CAUSE_W-1:0] cause_t;

endpackage

// File: rtl/hazard_scoreboard_unit_sat_down_counter.sv
// Loadable down-counter that saturates at zero; a load wins over the
// same-cycle decrement.
module sat_down_counter #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic [LAT_W-1:0] cnt_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: per-register countdown scoreboard plus occupancy
// counter for the non-pipelined unit; produces stall/bubble/flush controls.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS           = 32,
  parameter int REG_AW             = 5,
  parameter int LAT_W              = 4,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic [REG_AW-1:0]   id_rs3,
  input  logic [2:0]          id_rs_use,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_rd_we,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                id_unpiped,
  input  logic [LAT_W-1:0]    id_occ,
  input  logic                flush,
  output logic                pcwrite,
  output logic                ifid_write,
  output logic                hazard,
  output logic                issue,
  output logic [2:0]          stall_cause,
  output logic [NUM_REGS-1:0] sb_pending
);

  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] cnt_load;
  logic [LAT_W-1:0]    occ;
  logic                rd_live;
  logic                raw;
  logic                waw;
  logic                strc;
  logic                stall;

  // Register 0 is invisible to the scoreboard when it is hardwired to zero.
  function automatic logic reg_live(input logic [REG_AW-1:0] r);
    return !((ZERO_REG_HARDWIRED != 0) && (r == '0));
  endfunction

  assign rd_live = id_rd_we && reg_live(id_rd);

  always_comb begin
    raw = 1'b0;
    if (id_rs_use[0] && reg_live(id_rs1) && (cnt[id_rs1] != '0)) raw = 1'b1;
    if (id_rs_use[1] && reg_live(id_rs2) && (cnt[id_rs2] != '0)) raw = 1'b1;
    if (id_rs_use[2] && reg_live(id_rs3) && (cnt[id_rs3] != '0)) raw = 1'b1;
    raw = raw && id_valid;
  end

  // WAW only when the older result would land after this one.
  assign waw   = id_valid && rd_live && (cnt[id_rd] > id_lat);
  assign strc  = id_valid && id_unpiped && (occ != '0);
  assign stall = (raw || waw || strc) && !flush;

  always_comb begin
    pcwrite     = 1'b1;
    ifid_write  = 1'b1;
    hazard      = 1'b0;
    issue       = id_valid;
    stall_cause = '0;
    if (flush) begin
      hazard = 1'b1;
      issue  = 1'b0;
    end else if (stall) begin
      pcwrite                   = 1'b0;
      ifid_write                = 1'b0;
      hazard                    = 1'b1;
      issue                     = 1'b0;
      stall_cause[CAUSE_RAW]    = raw;
      stall_cause[CAUSE_WAW]    = waw;
      stall_cause[CAUSE_STRUCT] = strc;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
    assign cnt_load[g]   = issue && rd_live && (id_rd == REG_AW'(g));
    assign sb_pending[g] = (cnt[g] != '0);

    sat_down_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load[g]),
      .load_val_i (id_lat),
      .cnt_o      (cnt[g])
    );
  end

  sat_down_counter #(.LAT_W(LAT_W)) u_occ (
    .clk        (clk),
    .rst        (rst),
    .load_i     (issue && id_unpiped),
    .load_val_i (id_occ),
    .cnt_o      (occ)
  );

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench: the driver predicts each cycle's controls from a
// ready-time model of the pipeline; a negedge monitor compares the DUT.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rs3 = '0, id_rd = '0;
  logic [2:0]    id_rs_use = '0;
  logic          id_rd_we = 1'b0;
  logic [3:0]    id_lat = '0, id_occ = '0;
  logic          id_unpiped = 1'b0;
  logic          flush = 1'b0;
  logic          pcwrite, ifid_write, hazard, issue;
  logic [2:0]    stall_cause;
  logic [NR-1:0] sb_pending;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs3(id_rs3), .id_rs_use(id_rs_use), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_lat(id_lat), .id_unpiped(id_unpiped), .id_occ(id_occ), .flush(flush),
    .pcwrite(pcwrite), .ifid_write(ifid_write), .hazard(hazard), .issue(issue),
    .stall_cause(stall_cause), .sb_pending(sb_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pcw, ifw, haz, iss;
    logic [2:0]    cause;
    logic [NR-1:0] pend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: the cycle at which each register's result becomes forwardable.
  int cyc = 0;
  int ready [NR];
  int occ_ready = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rem(input int r);
    return (ready[r] > cyc) ? ready[r] - cyc : 0;
  endfunction

  function automatic bit live(input int r);
    return r != 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) ready[i] = 0;
    occ_ready = 0;
  endtask

  task automatic drive(input logic v, input int r1, input int r2, input int r3,
                       input logic [2:0] u, input int rd, input logic we, input int lat,
                       input logic unp, input int occ, input logic fl, input bit do_rst);
    exp_t e;
    bit   raw_e, waw_e, str_e, stall_e;
    int   srcs [3];
    @(posedge clk);
    #1;
    if (do_rst) begin
      rst = 1'b1;
      #1;
      chk("async_rst_pending", sb_pending, 0);
      rst = 1'b0;
      model_clear();
    end
    id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rs3 = 5'(r3); id_rs_use = u;
    id_rd = 5'(rd); id_rd_we = we; id_lat = 4'(lat); id_unpiped = unp;
    id_occ = 4'(occ); flush = fl;

    srcs[0] = r1; srcs[1] = r2; srcs[2] = r3;
    raw_e = 0;
    for (int k = 0; k < 3; k++)
      if (u[k] && live(srcs[k]) && rem(srcs[k]) != 0) raw_e = 1;
    raw_e   = raw_e && v;
    waw_e   = v && we && live(rd) && (rem(rd) > lat);
    str_e   = v && unp && (occ_ready > cyc);
    stall_e = (raw_e || waw_e || str_e) && !fl;

    e.pcw   = !stall_e;
    e.ifw   = !stall_e;
    e.haz   = stall_e || fl;
    e.iss   = v && !fl && !stall_e;
    e.cause = stall_e ? {str_e, waw_e, raw_e} : 3'b000;
    for (int i = 0; i < NR; i++) e.pend[i] = (rem(i) != 0);
    q.push_back(e);

    if (e.iss && we && live(rd)) ready[rd] = cyc + 1 + lat;
    if (e.iss && unp) occ_ready = cyc + 1 + occ;
    cyc++;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Re-present one instruction until the DUT issues it; returns DUT stall cycles.
  task automatic until_issue(input string nm, input int r1, input int r2, input int r3,
                             input logic [2:0] u, input int rd, input logic we, input int lat,
                             input logic unp, input int occ, input bit do_rst,
                             output int stalls);
    bit got = 0;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1, r1, r2, r3, u, rd, we, lat, unp, occ, 0, (k == 0) ? do_rst : 1'b0);
      #1;
      if (issue === 1'b1) begin
        got = 1;
        break;
      end
      stalls++;
    end
    if (!got) chk({nm, "_issue_timeout"}, 0, 1);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pcwrite", pcwrite, e.pcw);
      chk("ifid_write", ifid_write, e.ifw);
      chk("hazard", hazard, e.haz);
      chk("issue", issue, e.iss);
      chk("stall_cause", stall_cause, e.cause);
      chk("sb_pending", sb_pending, e.pend);
    end
  end

  initial begin
    int st;
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle();
    idle();

    // Load-use: one bubble
    drive(1, 0, 0, 0, 3'b000, 5, 1, LAT_LOAD, 0, 0, 0, 0);
    until_issue("load_use", 5, 1, 0, 3'b011, 6, 1, LAT_ALU, 0, 0, 0, st);
    chk("load_use_stalls", st, 1);

    // Mul then dependent: three stalls
    drive(1, 0, 0, 0, 3'b000, 7, 1, LAT_MUL, 0, 0, 0, 0);
    until_issue("mul_dep", 7, 0, 0, 3'b001, 9, 1, LAT_ALU, 0, 0, 0, st);
    chk("mul_dep_stalls", st, 3);

    // Div x8 lat 8, then ALU writing x8: WAW for eight cycles
    drive(1, 0, 0, 0, 3'b000, 8, 1, 8, 0, 0, 0, 0);
    until_issue("waw", 2, 3, 0, 3'b011, 8, 1, LAT_ALU, 0, 0, 0, st);
    chk("waw_stalls", st, 8);

    // Unpiped occupancy: structural stall of five cycles
    drive(1, 0, 0, 0, 3'b000, 10, 1, 2, 1, 5, 0, 0);
    until_issue("struct", 11, 0, 0, 3'b001, 12, 1, 2, 1, 5, 0, st);
    chk("struct_stalls", st, 5);
    // Independent pipelined op inside the occupancy window
    until_issue("struct_indep", 13, 0, 0, 3'b001, 14, 1, LAT_ALU, 0, 0, 0, st);
    chk("indep_stalls", st, 0);

    // Flush on top of a RAW stall, then the dependent still waits
    drive(1, 0, 0, 0, 3'b000, 15, 1, LAT_VEC, 0, 0, 0, 0);
    drive(1, 15, 0, 0, 3'b001, 16, 1, 0, 0, 0, 1, 0);
    drive(1, 15, 0, 0, 3'b001, 16, 1, 0, 0, 0, 0, 0);
    idle();
    idle();

    // Async reset mid-stall
    drive(1, 0, 0, 0, 3'b000, 4, 1, LAT_MUL, 0, 0, 0, 0);
    drive(1, 4, 0, 0, 3'b001, 17, 1, 0, 0, 0, 0, 0);
    until_issue("rst_dep", 4, 0, 0, 3'b001, 17, 1, 0, 0, 0, 1, st);
    chk("rst_dep_stalls", st, 0);

    // x0 as destination never marks, as source never stalls
    drive(1, 0, 0, 0, 3'b000, 0, 1, 5, 0, 0, 0, 0);
    until_issue("x0_src", 0, 0, 0, 3'b111, 0, 1, 0, 0, 0, 0, st);
    chk("x0_stalls", st, 0);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(3, 0) != 0,
            $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0),
            3'($urandom_range(7, 0)), $urandom_range(7, 0), $urandom_range(1, 0) != 0,
            $urandom_range(6, 0), $urandom_range(7, 0) == 0, $urandom_range(6, 0),
            $urandom_range(9, 0) == 0, $urandom_range(99, 0) == 0);
    end
    idle();

    for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) chk("queue_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the single-cycle load-use detector for the RV64IV pipeline.
- A per-register countdown scoreboard tracks pending results of variable-latency producers (loads, mul/div, vector ops).
- An occupancy counter covers the non-pipelined vector/divide unit.
- Generates the ID-stage stall/bubble controls (RAW, WAW, structural) and honours branch flush.

Parameters:
- NUM_REGS, 32, architectural registers tracked.
- REG_AW, 5, register index width (clog2 NUM_REGS).
- LAT_W, 4, latency/occupancy counter width (max 15 cycles).
- ZERO_REG_HARDWIRED, 1, when 1, register 0 never creates or suffers a hazard (set 0 for vector file).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs1  in  REG_AW  source 1
- id_rs2  in  REG_AW  source 2
- id_rs3  in  REG_AW  source 3 (vector FMA)
- id_rs_use  in  3  per-source read enable, bit0=rs1
- id_rd  in  REG_AW  destination
- id_rd_we  in  1  instruction writes id_rd
- id_lat  in  LAT_W  cycles after issue before result is forwardable (ALU 0, load 1)
- id_unpiped  in  1  instruction uses the non-pipelined unit
- id_occ  in  LAT_W  unit occupancy in cycles when id_unpiped
- flush  in  1  taken branch/mispredict resolved in EX; kills ID instruction
- pcwrite  out  1  PC update enable
- ifid_write  out  1  IF/ID register write enable
- hazard  out  1  insert bubble into ID/EX
- issue  out  1  ID instruction advances this cycle
- stall_cause  out  3  {struct, waw, raw} of current stall
- sb_pending  out  NUM_REGS  bit i = cnt[i] != 0

Behaviour:
- State: cnt[NUM_REGS] of LAT_W bits; occ of LAT_W bits. All cleared asynchronously on rst. No other state.
- All outputs are combinational from state plus ID inputs; zero-latency decision.
- Reset/idle values (state 0): pcwrite=1, ifid_write=1, hazard=0, stall_cause=0, sb_pending=0. issue follows id_valid & !flush.
- Masking: a source or destination equal to 0 is ignored when ZERO_REG_HARDWIRED=1.
- raw = id_valid & any used source s with cnt[s] != 0.
- waw = id_valid & id_rd_we & cnt[id_rd] > id_lat. Prevents an older result landing after a younger one.
- strc = id_valid & id_unpiped & occ != 0.
- stall = (raw | waw | strc) & !flush.
- When stall: pcwrite=0, ifid_write=0, hazard=1, issue=0, stall_cause={strc,waw,raw}.
- When flush: pcwrite=1, ifid_write=1, hazard=1, issue=0, stall_cause=0. Flush overrides stall, because the killed instruction must not hold the pipe.
- Otherwise: pcwrite=1, ifid_write=1, hazard=0, issue=id_valid.
- Every cycle, each cnt[i] != 0 decrements by 1, saturating at 0.
- On issue & id_rd_we (rd not masked): cnt[id_rd] <= id_lat. The load overrides the same-cycle decrement. id_lat=0 leaves the entry clear.
- occ decrements each cycle, saturating at 0. On issue & id_unpiped: occ <= id_occ (load wins).
- Load-use equivalence: load with id_lat=1 followed by a dependent gives exactly one bubble.
- A stalled instruction re-evaluates every cycle; it issues the first cycle all counters it depends on reach 0.
- Reset mid-stall clears all counters immediately. The next cycle sees no hazard.

Decomposition:
- Shared package hazard_pkg holds:
  - stall-cause bit positions (CAUSE_RAW=0, CAUSE_WAW=1, CAUSE_STRUCT=2);
  - latency constants (LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3, LAT_VEC default 4).
- One natural sub-module: sat_down_counter (LAT_W-bit load/decrement/saturate). Instantiated NUM_REGS+1 times via generate.

Test Plan:
- Load x5 (lat=1) then "add x6,x5,x1" → one cycle with hazard=1, pcwrite=0, stall_cause=3'b001; add issues on the next cycle.
- Mul x7 (lat=3) then dependent on x7 → exactly 3 stall cycles; sb_pending[7] high for 3 cycles, then 0.
- Issue div x8 (lat=8), then "add x8,x2,x3" (lat=0) → WAW stall (cause 3'b010) until cnt[8]=0, i.e. 8 cycles.
- Unpiped op with occ=5, then another unpiped op with no register overlap → 5 stall cycles with cause 3'b100. A non-unpiped independent op in the same window issues with no stall.
- RAW stall active and flush=1 in the same cycle → pcwrite=1, ifid_write=1, hazard=1, issue=0, stall_cause=0. Scoreboard continues decrementing.
- cnt[4]=3 and rst pulsed asynchronously mid-cycle → sb_pending=0 immediately. A dependent on x4 issues the next cycle. Also cover: source x0 with cnt forced via id_rd=0 never stalls.
